// File: rtl/lsu_dbus_pkg.sv
// Shared widths, micro-op codes, exception bit positions and LSU state encodings
// for the load/store unit and its lane-steering helper.
package lsu_dbus_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_W      = 32;
    localparam int unsigned ALU_OP_W   = 8;
    localparam int unsigned XLEN       = 32;

    localparam logic [ALU_OP_W-1:0] UOP_CODE_NOP = 8'h00;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_ADD = 8'h01;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_LB  = 8'h10;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_LH  = 8'h11;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_LW  = 8'h12;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_LBU = 8'h14;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_LHU = 8'h15;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_SB  = 8'h18;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_SH  = 8'h19;
    localparam logic [ALU_OP_W-1:0] UOP_CODE_SW  = 8'h1a;

    localparam int unsigned EXC_LOAD_MISALIGN  = 4;
    localparam int unsigned EXC_LOAD_FAULT     = 5;
    localparam int unsigned EXC_STORE_MISALIGN = 6;
    localparam int unsigned EXC_STORE_FAULT    = 7;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [3:0]      be;
        logic [XLEN-1:0] wdata;
    } dbus_req_t;

    function automatic logic is_load_uop(input logic [ALU_OP_W-1:0] op);
        return op inside {UOP_CODE_LB, UOP_CODE_LH, UOP_CODE_LW, UOP_CODE_LBU, UOP_CODE_LHU};
    endfunction

    function automatic logic is_store_uop(input logic [ALU_OP_W-1:0] op);
        return op inside {UOP_CODE_SB, UOP_CODE_SH, UOP_CODE_SW};
    endfunction

    function automatic logic is_mem_uop(input logic [ALU_OP_W-1:0] op);
        return is_load_uop(op) || is_store_uop(op);
    endfunction

    // Halfwords need bit 0 clear, words need both low bits clear.
    function automatic logic is_misaligned(input logic [ALU_OP_W-1:0] op, input logic [1:0] lo);
        logic half;
        logic word;
        half = op inside {UOP_CODE_LH, UOP_CODE_LHU, UOP_CODE_SH};
        word = op inside {UOP_CODE_LW, UOP_CODE_SW};
        return (half && lo[0]) || (word && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_dbus_align.sv
// Byte-lane steering for stores and lane extract plus sign/zero extend for loads.
module lsu_dbus_align
    import lsu_dbus_pkg::*;
(
    input  logic [ALU_OP_W-1:0] uopcode_i,
    input  logic [1:0]          addr_lo_i,
    input  logic [XLEN-1:0]     wdata_i,
    input  logic [XLEN-1:0]     rdata_i,
    output logic [3:0]          be_o,
    output logic [XLEN-1:0]     wdata_o,
    output logic [XLEN-1:0]     ldata_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (uopcode_i)
            UOP_CODE_SB: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            UOP_CODE_SH: begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        case (uopcode_i)
            UOP_CODE_LB:  ldata_o = {{24{shifted[7]}}, shifted[7:0]};
            UOP_CODE_LBU: ldata_o = {24'h0, shifted[7:0]};
            UOP_CODE_LH:  ldata_o = {{16{shifted[15]}}, shifted[15:0]};
            UOP_CODE_LHU: ldata_o = {16'h0, shifted[15:0]};
            default:      ldata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_dbus.sv
// Load/store unit: decodes memory micro-ops, checks alignment, runs the
// req/gnt/rvalid data-bus transaction and stalls the pipeline until it completes.
module lsu_dbus
    import lsu_dbus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  rd_we_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic [REG_W-1:0]      rd_wdata_i,
    input  logic [ALU_OP_W-1:0]   uopcode_i,
    input  logic [XLEN-1:0]       mem_addr_i,
    input  logic [XLEN-1:0]       mem_wdata_i,
    input  logic                  csr_we_i,
    input  logic [XLEN-1:0]       csr_waddr_i,
    input  logic [XLEN-1:0]       csr_wdata_i,
    input  logic [XLEN-1:0]       exception_i,
    input  logic [XLEN-1:0]       pc_i,
    input  logic [XLEN-1:0]       inst_i,
    output logic                  dbus_req_o,
    output logic                  dbus_we_o,
    output logic [XLEN-1:0]       dbus_addr_o,
    output logic [3:0]            dbus_be_o,
    output logic [XLEN-1:0]       dbus_wdata_o,
    input  logic                  dbus_gnt_i,
    input  logic                  dbus_rvalid_i,
    input  logic [XLEN-1:0]       dbus_rdata_i,
    input  logic                  dbus_err_i,
    output logic                  stall_req_o,
    output logic                  rd_we_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [REG_W-1:0]      rd_wdata_o,
    output logic                  csr_we_o,
    output logic [XLEN-1:0]       csr_waddr_o,
    output logic [XLEN-1:0]       csr_wdata_o,
    output logic [XLEN-1:0]       exception_o,
    output logic [XLEN-1:0]       pc_o,
    output logic [XLEN-1:0]       inst_o
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            fault_q, fault_d;
    logic            kill_q, kill_d;

    logic            is_mem;
    logic            is_ld;
    logic            misalign;
    logic            timeout;
    logic [XLEN-1:0] ldata;
    dbus_req_t       breq;

    assign is_mem   = is_mem_uop(uopcode_i);
    assign is_ld    = is_load_uop(uopcode_i);
    assign misalign = is_misaligned(uopcode_i, mem_addr_i[1:0]);
    assign timeout  = (cnt_q == TO_LAST);

    lsu_dbus_align u_align (
        .uopcode_i (uopcode_i),
        .addr_lo_i (mem_addr_i[1:0]),
        .wdata_i   (mem_wdata_i),
        .rdata_i   (rdata_q),
        .be_o      (breq.be),
        .wdata_o   (breq.wdata),
        .ldata_o   (ldata)
    );

    // Pipeline is stalled for the whole access, so the request is taken straight from the held inputs.
    assign breq.we   = is_store_uop(uopcode_i);
    assign breq.addr = {mem_addr_i[31:2], 2'b00};

    assign dbus_we_o    = breq.we;
    assign dbus_addr_o  = breq.addr;
    assign dbus_be_o    = breq.be;
    assign dbus_wdata_o = breq.wdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        kill_d  = kill_q;
        case (state_q)
            LSU_IDLE: begin
                cnt_d   = 8'd0;
                fault_d = 1'b0;
                kill_d  = 1'b0;
                if (is_mem && exception_i == '0 && !misalign && !flush_i) begin
                    state_d = LSU_REQ;
                end
            end
            LSU_REQ: begin
                cnt_d = cnt_q + 8'd1;
                // A granted request must still see its response, so flush only kills it.
                if (dbus_gnt_i) begin
                    state_d = LSU_WAIT;
                    if (flush_i) kill_d = 1'b1;
                end else if (flush_i) begin
                    state_d = LSU_IDLE;
                end else if (timeout) begin
                    state_d = LSU_DONE;
                    fault_d = 1'b1;
                end
            end
            LSU_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (flush_i) kill_d = 1'b1;
                if (dbus_rvalid_i) begin
                    state_d = LSU_DONE;
                    rdata_d = dbus_rdata_i;
                    fault_d = dbus_err_i;
                end else if (timeout) begin
                    state_d = LSU_DONE;
                    fault_d = 1'b1;
                end
            end
            LSU_DONE: begin
                cnt_d   = 8'd0;
                state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LSU_IDLE;
            cnt_q   <= 8'd0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        dbus_req_o  = 1'b0;
        stall_req_o = 1'b0;
        rd_we_o     = rd_we_i;
        rd_addr_o   = rd_addr_i;
        rd_wdata_o  = rd_wdata_i;
        csr_we_o    = csr_we_i;
        csr_waddr_o = csr_waddr_i;
        csr_wdata_o = csr_wdata_i;
        exception_o = exception_i;
        pc_o        = pc_i;
        inst_o      = inst_i;
        if (rst_i) begin
            rd_we_o  = 1'b0;
            csr_we_o = 1'b0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (flush_i) begin
                        rd_we_o     = 1'b0;
                        csr_we_o    = 1'b0;
                        exception_o = '0;
                    end else if (is_mem && exception_i == '0) begin
                        rd_we_o = 1'b0;
                        if (misalign) begin
                            exception_o = exception_i |
                                (32'h1 << (is_ld ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN));
                        end else begin
                            stall_req_o = 1'b1;
                            csr_we_o    = 1'b0;
                        end
                    end
                end
                LSU_REQ: begin
                    dbus_req_o  = 1'b1;
                    stall_req_o = 1'b1;
                    rd_we_o     = 1'b0;
                    csr_we_o    = 1'b0;
                end
                LSU_WAIT: begin
                    stall_req_o = 1'b1;
                    rd_we_o     = 1'b0;
                    csr_we_o    = 1'b0;
                end
                LSU_DONE: begin
                    if (flush_i || kill_q) begin
                        rd_we_o     = 1'b0;
                        csr_we_o    = 1'b0;
                        exception_o = '0;
                    end else if (fault_q) begin
                        rd_we_o     = 1'b0;
                        exception_o = exception_i |
                            (32'h1 << (is_ld ? EXC_LOAD_FAULT : EXC_STORE_FAULT));
                    end else if (is_ld) begin
                        rd_wdata_o = ldata;
                    end else begin
                        rd_we_o = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dbus.sv
// Directed bench for lsu_dbus: aligned/misaligned loads and stores, bus errors,
// timeout, flush and reset behaviour.
module tb_lsu_dbus;
    import lsu_dbus_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  flush_i;
    logic                  rd_we_i;
    logic [REG_ADDR_W-1:0] rd_addr_i;
    logic [REG_W-1:0]      rd_wdata_i;
    logic [ALU_OP_W-1:0]   uopcode_i;
    logic [31:0]           mem_addr_i, mem_wdata_i;
    logic                  csr_we_i;
    logic [31:0]           csr_waddr_i, csr_wdata_i, exception_i, pc_i, inst_i;
    logic                  dbus_req_o, dbus_we_o;
    logic [31:0]           dbus_addr_o;
    logic [3:0]            dbus_be_o;
    logic [31:0]           dbus_wdata_o;
    logic                  dbus_gnt_i, dbus_rvalid_i, dbus_err_i;
    logic [31:0]           dbus_rdata_i;
    logic                  stall_req_o, rd_we_o, csr_we_o;
    logic [REG_ADDR_W-1:0] rd_addr_o;
    logic [REG_W-1:0]      rd_wdata_o;
    logic [31:0]           csr_waddr_o, csr_wdata_o, exception_o, pc_o, inst_o;

    int total = 0;
    int bad   = 0;

    lsu_dbus #(.TIMEOUT_CYCLES(255)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_wdata_i(rd_wdata_i),
        .uopcode_i(uopcode_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
        .exception_i(exception_i), .pc_i(pc_i), .inst_i(inst_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i),
        .dbus_rdata_i(dbus_rdata_i), .dbus_err_i(dbus_err_i),
        .stall_req_o(stall_req_o), .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o),
        .rd_wdata_o(rd_wdata_o), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
        .csr_wdata_o(csr_wdata_o), .exception_o(exception_o), .pc_o(pc_o), .inst_o(inst_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven mid-cycle.
    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd);
        uopcode_i   = op;
        mem_addr_i  = addr;
        mem_wdata_i = wd;
        rd_we_i     = 1'b1;
        rd_addr_i   = 5'd7;
        rd_wdata_i  = 32'h0bad0bad;
        csr_we_i    = 1'b1;
        csr_waddr_i = 32'h0000_0300;
        csr_wdata_i = 32'h0000_1234;
        exception_i = 32'h0;
        pc_i        = 32'h8000_0010;
        inst_i      = 32'h0000_0013;
    endtask

    task automatic set_nop();
        set_op(UOP_CODE_NOP, 32'h0, 32'h0);
        rd_we_i  = 1'b0;
        csr_we_i = 1'b0;
    endtask

    // Minimum-latency access: gnt in the first REQ cycle, rvalid the cycle after.
    task automatic access(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdata, input logic err,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic exp_dwe,
                          input logic exp_we, input logic [31:0] exp_rdw, input logic [31:0] exp_exc);
        set_op(op, addr, wd);
        #1;
        chk({tag, "_idle_stall"}, 32'(stall_req_o), 32'h1);
        chk({tag, "_idle_rdwe"}, 32'(rd_we_o), 32'h0);
        step();
        chk({tag, "_req"}, 32'(dbus_req_o), 32'h1);
        chk({tag, "_addr"}, dbus_addr_o, {addr[31:2], 2'b00});
        chk({tag, "_be"}, 32'(dbus_be_o), 32'(exp_be));
        chk({tag, "_wdata"}, dbus_wdata_o, exp_wd);
        chk({tag, "_dwe"}, 32'(dbus_we_o), 32'(exp_dwe));
        chk({tag, "_req_stall"}, 32'(stall_req_o), 32'h1);
        dbus_gnt_i = 1'b1;
        step();
        dbus_gnt_i = 1'b0;
        chk({tag, "_wait_req"}, 32'(dbus_req_o), 32'h0);
        chk({tag, "_wait_stall"}, 32'(stall_req_o), 32'h1);
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = rdata;
        dbus_err_i    = err;
        step();
        dbus_rvalid_i = 1'b0;
        dbus_err_i    = 1'b0;
        dbus_rdata_i  = 32'h0;
        #1;
        chk({tag, "_done_stall"}, 32'(stall_req_o), 32'h0);
        chk({tag, "_done_rdwe"}, 32'(rd_we_o), 32'(exp_we));
        if (exp_we) chk({tag, "_done_rdata"}, rd_wdata_o, exp_rdw);
        chk({tag, "_done_exc"}, exception_o, exp_exc);
        step();
        set_nop();
        #1;
        chk({tag, "_after_stall"}, 32'(stall_req_o), 32'h0);
    endtask

    initial begin
        int n;
        rst_i = 1'b1;
        flush_i = 1'b0;
        dbus_gnt_i = 1'b0;
        dbus_rvalid_i = 1'b0;
        dbus_err_i = 1'b0;
        dbus_rdata_i = 32'h0;
        set_op(UOP_CODE_LW, 32'h100, 32'h0);
        step();
        step();
        chk("rst_req", 32'(dbus_req_o), 32'h0);
        chk("rst_stall", 32'(stall_req_o), 32'h0);
        chk("rst_rdwe", 32'(rd_we_o), 32'h0);
        chk("rst_csrwe", 32'(csr_we_o), 32'h0);
        set_nop();
        rst_i = 1'b0;
        step();

        // Non-memory op passes through in the same cycle.
        set_op(UOP_CODE_ADD, 32'h0, 32'h0);
        rd_wdata_i = 32'h0000_0055;
        #1;
        chk("pass_rdwe", 32'(rd_we_o), 32'h1);
        chk("pass_rdata", rd_wdata_o, 32'h0000_0055);
        chk("pass_csr", csr_wdata_o, 32'h0000_1234);
        chk("pass_stall", 32'(stall_req_o), 32'h0);
        chk("pass_req", 32'(dbus_req_o), 32'h0);
        step();

        access("lw", UOP_CODE_LW, 32'h100, 32'h1111_1111, 32'hdeadbeef, 1'b0,
               4'b1111, 32'h1111_1111, 1'b0, 1'b1, 32'hdeadbeef, 32'h0);
        access("lb", UOP_CODE_LB, 32'h103, 32'h0, 32'h80aabbcc, 1'b0,
               4'b1111, 32'h0, 1'b0, 1'b1, 32'hffffff80, 32'h0);
        access("lbu", UOP_CODE_LBU, 32'h103, 32'h0, 32'h80aabbcc, 1'b0,
               4'b1111, 32'h0, 1'b0, 1'b1, 32'h00000080, 32'h0);
        access("lh", UOP_CODE_LH, 32'h102, 32'h0, 32'h80aabbcc, 1'b0,
               4'b1111, 32'h0, 1'b0, 1'b1, 32'hffff80aa, 32'h0);
        access("lhu", UOP_CODE_LHU, 32'h100, 32'h0, 32'h1234f00d, 1'b0,
               4'b1111, 32'h0, 1'b0, 1'b1, 32'h0000f00d, 32'h0);
        access("sh", UOP_CODE_SH, 32'h202, 32'h1234abcd, 32'h0, 1'b0,
               4'b1100, 32'habcdabcd, 1'b1, 1'b0, 32'h0, 32'h0);
        access("sb", UOP_CODE_SB, 32'h201, 32'h000000a5, 32'h0, 1'b0,
               4'b0010, 32'ha5a5a5a5, 1'b1, 1'b0, 32'h0, 32'h0);
        access("sw_err", UOP_CODE_SW, 32'h300, 32'hcafef00d, 32'h0, 1'b1,
               4'b1111, 32'hcafef00d, 1'b1, 1'b0, 32'h0, 32'h0000_0080);
        access("lw_err", UOP_CODE_LW, 32'h304, 32'h0, 32'h5555_5555, 1'b1,
               4'b1111, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0020);

        // Misaligned accesses trap immediately without touching the bus.
        set_op(UOP_CODE_LW, 32'h101, 32'h0);
        #1;
        chk("mis_lw_req", 32'(dbus_req_o), 32'h0);
        chk("mis_lw_stall", 32'(stall_req_o), 32'h0);
        chk("mis_lw_rdwe", 32'(rd_we_o), 32'h0);
        chk("mis_lw_exc", exception_o, 32'h0000_0010);
        step();
        chk("mis_lw_noreq", 32'(dbus_req_o), 32'h0);
        set_op(UOP_CODE_SH, 32'h203, 32'h0);
        #1;
        chk("mis_sh_exc", exception_o, 32'h0000_0040);
        chk("mis_sh_stall", 32'(stall_req_o), 32'h0);
        step();

        // Memory op already carrying an exception is passed through.
        set_op(UOP_CODE_LW, 32'h100, 32'h0);
        exception_i = 32'h0000_0004;
        #1;
        chk("exc_in_stall", 32'(stall_req_o), 32'h0);
        chk("exc_in_exc", exception_o, 32'h0000_0004);
        chk("exc_in_rdwe", 32'(rd_we_o), 32'h1);
        step();
        chk("exc_in_noreq", 32'(dbus_req_o), 32'h0);
        set_nop();
        step();

        // Grant withheld: request drops after 255 REQ cycles with a load fault.
        set_op(UOP_CODE_LW, 32'h100, 32'h0);
        step();
        n = 0;
        while (dbus_req_o && n < 300) begin
            n++;
            step();
        end
        chk("to_req_cycles", 32'(n), 32'd255);
        chk("to_exc", exception_o, 32'h0000_0020);
        chk("to_rdwe", 32'(rd_we_o), 32'h0);
        step();
        set_nop();
        #1;
        chk("to_idle_stall", 32'(stall_req_o), 32'h0);
        step();

        // Flush in WAIT: response is still consumed, DONE is a bubble.
        set_op(UOP_CODE_LW, 32'h100, 32'h0);
        step();
        dbus_gnt_i = 1'b1;
        step();
        dbus_gnt_i = 1'b0;
        flush_i = 1'b1;
        #1;
        chk("fl_wait_stall", 32'(stall_req_o), 32'h1);
        step();
        flush_i = 1'b0;
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i = 32'h1234_5678;
        #1;
        chk("fl_wait2_stall", 32'(stall_req_o), 32'h1);
        step();
        dbus_rvalid_i = 1'b0;
        #1;
        chk("fl_done_rdwe", 32'(rd_we_o), 32'h0);
        chk("fl_done_csrwe", 32'(csr_we_o), 32'h0);
        chk("fl_done_exc", exception_o, 32'h0);
        chk("fl_done_stall", 32'(stall_req_o), 32'h0);
        step();
        set_nop();
        #1;
        chk("fl_idle_stall", 32'(stall_req_o), 32'h0);
        step();

        // Flush in REQ before grant abandons the request.
        set_op(UOP_CODE_LW, 32'h100, 32'h0);
        step();
        flush_i = 1'b1;
        #1;
        chk("flr_req", 32'(dbus_req_o), 32'h1);
        step();
        flush_i = 1'b0;
        set_nop();
        #1;
        chk("flr_idle_req", 32'(dbus_req_o), 32'h0);
        chk("flr_idle_stall", 32'(stall_req_o), 32'h0);
        step();

        // Reset mid-transaction, then a late rvalid is ignored in IDLE.
        set_op(UOP_CODE_LW, 32'h100, 32'h0);
        step();
        chk("rr_req", 32'(dbus_req_o), 32'h1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        set_nop();
        #1;
        chk("rr_after_req", 32'(dbus_req_o), 32'h0);
        chk("rr_after_stall", 32'(stall_req_o), 32'h0);
        dbus_rvalid_i = 1'b1;
        step();
        dbus_rvalid_i = 1'b0;
        set_op(UOP_CODE_ADD, 32'h0, 32'h0);
        #1;
        chk("late_rv_stall", 32'(stall_req_o), 32'h0);
        chk("late_rv_rdwe", 32'(rd_we_o), 32'h1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_dbus.md
Name: lsu_dbus

Overview:
Load/store unit on the consuming side of the EX→LSU pipeline register. It decodes the memory micro-op delivered each cycle, checks alignment, and runs a request/grant/response transaction on the data bus. It stalls the pipeline until the access completes, then forwards writeback, CSR and exception information to the MEM/WB register. Non-memory ops pass through with zero latency.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before an access fault is raised (8-bit counter).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  pipeline flush from ctrl
rd_we_i/rd_addr_i/rd_wdata_i  in  1/`RegAddrBus/`RegBus  GPR writeback from EX→LSU register
uopcode_i  in  `AluOpBus  micro-op (UOP_CODE_LB/LH/LW/LBU/LHU/SB/SH/SW are memory ops)
mem_addr_i/mem_wdata_i  in  32/32  effective address, store data
csr_we_i/csr_waddr_i/csr_wdata_i  in  1/32/32  CSR write, passed through
exception_i/pc_i/inst_i  in  32/32/32  exception vector, pc, instruction, passed through
dbus_req_o  out  1  bus request
dbus_we_o  out  1  1=store
dbus_addr_o  out  32  word-aligned address {mem_addr_i[31:2],2'b00}
dbus_be_o  out  4  byte enables
dbus_wdata_o  out  32  lane-replicated store data
dbus_gnt_i  in  1  request accepted
dbus_rvalid_i  in  1  response (load data or store ack)
dbus_rdata_i  in  32  load data
dbus_err_i  in  1  bus error, qualified by rvalid
stall_req_o  out  1  stall request to ctrl
rd_we_o/rd_addr_o/rd_wdata_o  out  1/`RegAddrBus/`RegBus  to MEM/WB
csr_we_o/csr_waddr_o/csr_wdata_o/exception_o  out  1/32/32/32  to MEM/WB

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset: state=IDLE, timeout counter=0, captured data=0.
- Reset values: dbus_req_o=0, stall_req_o=0. Outputs are combinational from state and inputs. In reset and non-IDLE/non-DONE states, rd_we_o=0 and csr_we_o=0.
- IDLE, non-memory op: all outputs equal the inputs in the same cycle. No stall.
- IDLE, memory op with exception_i==0 and aligned address: stall_req_o=1 and rd_we_o=0; next state is REQ.
- Misalignment: address bit 0 set for LH/LHU/SH, or bits [1:0] nonzero for LW/SW.
  - No bus access and no stall.
  - exception_o = exception_i with bit EXC_LOAD_MISALIGN (loads) or EXC_STORE_MISALIGN (stores) set; rd_we_o=0.
- Memory op with exception_i≠0: treat as a non-memory op; no bus access.
- REQ: dbus_req_o=1 with addr/we/be/wdata held stable until dbus_gnt_i; on gnt go to WAIT. stall_req_o=1.
- WAIT: stall_req_o=1; dbus_req_o=0.
  - On dbus_rvalid_i: capture rdata and err, then go to DONE.
  - Stores also wait for rvalid as completion.
- DONE: stall_req_o=0; outputs driven for exactly one cycle; next state IDLE.
  - Load: rd_wdata_o = extracted data, rd_we_o = rd_we_i.
  - Store: rd_we_o=0.
  - Error: rd_we_o=0 and exception_o gets EXC_LOAD_FAULT or EXC_STORE_FAULT.
- Minimum latency (gnt in REQ's first cycle, rvalid the next cycle): 3 stall cycles, result in the 4th.
- Byte enables:
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<{addr[1],1'b0}.
  - SW: 4'b1111.
  - Loads: be=4'b1111.
- Store data: SB wdata={4{b}}; SH wdata={2{h}}.
- Load extract: shift rdata right by addr[1:0]*8; LB/LH sign-extend; LBU/LHU zero-extend.
- Timeout: the counter increments in REQ/WAIT and clears in IDLE. On reaching TIMEOUT_CYCLES, go to DONE with the fault exception bit set and dbus_req_o dropped.
- flush_i:
  - In IDLE or DONE: outputs are a bubble (rd_we_o=0, csr_we_o=0, exception_o=0).
  - In REQ before gnt: drop request, go to IDLE.
  - In REQ with gnt in the same cycle, or in WAIT: set a kill flag and continue to the response. DONE then emits a bubble. The bus protocol requires every granted request to receive rvalid.
- rst_i mid-transaction: IDLE next cycle. A late rvalid is ignored in IDLE.
- gnt and rvalid in the same REQ cycle is illegal (the bus guarantees rvalid ≥1 cycle after gnt).

Decomposition:
- defines.v gains:
  - exception bit positions EXC_LOAD_MISALIGN, EXC_STORE_MISALIGN, EXC_LOAD_FAULT, EXC_STORE_FAULT;
  - LSU state encodings;
  - a helper macro identifying memory uopcodes.
- One sub-module, lsu_align: purely combinational. It produces be/wdata lane steering and load extract/extend from uopcode, addr[1:0] and rdata.

Test Plan:
- LW addr 0x100, gnt in the first REQ cycle, rvalid the next with rdata 0xDEADBEEF → stall 3 cycles; DONE: rd_wdata_o=0xDEADBEEF, rd_we_o=1.
- LB addr 0x103, rdata 0x80AABBCC → be=4'b1111, rd_wdata_o=0xFFFFFF80. Repeat as LBU → 0x00000080.
- SH addr 0x202, wdata 0x1234ABCD → dbus_be_o=4'b1100, dbus_wdata_o=0xABCDABCD, dbus_we_o=1, rd_we_o=0 in DONE.
- LW addr 0x101 → no dbus_req_o, stall_req_o=0, EXC_LOAD_MISALIGN set the same cycle.
- gnt withheld for 255 cycles → dbus_req_o drops, EXC_LOAD_FAULT set. Separately, rvalid with dbus_err_i=1 on SW → EXC_STORE_FAULT set.
- flush_i in WAIT, then rvalid → DONE emits rd_we_o=0 and exception_o=0; IDLE follows. rst_i asserted in REQ → dbus_req_o=0 the next cycle.
